// File: rtl/pll_reconfig_gen.sv
// pll_reconfig_gen: counter-based output stage for the PLL/MMCM models.
// Divides the VCO clock into CHANNELS outputs, each with its own divide,
// high time and phase offset. Accepts runtime reconfiguration over a
// valid/ready handshake and re-aligns every channel after each change.
module pll_reconfig_gen #(
    parameter int CHANNELS       = 6,
    parameter int CNT_W          = 8,
    parameter int DEFAULT_DIVIDE = 4,
    parameter int LOCK_CYCLES    = 16,
    localparam int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                PWRDWN,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CNT_W-1:0]    cfg_divide,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_phase,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic                LOCKED
);

    localparam logic [1:0] S_ALIGN    = 2'd0;
    localparam logic [1:0] S_RUN_WAIT = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;
    localparam logic [1:0] S_DOWN     = 2'd3;

    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIVIDE);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIVIDE / 2);

    logic [1:0]          r_state;
    logic [LK_W-1:0]     r_lock_cnt;
    logic                r_err;

    logic [CNT_W-1:0]    r_div    [CHANNELS];
    logic [CNT_W-1:0]    r_high   [CHANNELS];
    logic [CNT_W-1:0]    r_phase  [CHANNELS];
    logic [CNT_W-1:0]    r_delay  [CHANNELS];
    logic [CNT_W-1:0]    r_period [CHANNELS];
    logic [CHANNELS-1:0] r_clk;

    logic                w_run;
    logic                w_ready;
    logic                w_xfer;
    logic                w_cfg_ok;
    logic                w_accept;
    logic                w_reject;
    logic [31:0]         w_sel_ext;

    // Handshake and request validation. cfg_ready depends only on state,
    // RST and PWRDWN, never on cfg_* inputs.
    assign w_run     = (r_state == S_RUN_WAIT) || (r_state == S_LOCKED);
    assign w_ready   = w_run && !PWRDWN && !RST;
    assign w_xfer    = cfg_valid && w_ready;
    assign w_sel_ext = 32'(cfg_sel);
    assign w_cfg_ok  = (cfg_divide >= CNT_W'(2)) &&
                       (cfg_high   >= CNT_W'(1)) &&
                       (cfg_high   <  cfg_divide) &&
                       (cfg_phase  <  cfg_divide) &&
                       (w_sel_ext  <  32'(CHANNELS));
    assign w_accept  = w_xfer && w_cfg_ok;
    assign w_reject  = w_xfer && !w_cfg_ok;

    assign cfg_ready = w_ready;
    assign cfg_err   = r_err;
    assign clk_out   = r_clk;
    assign LOCKED    = (r_state == S_LOCKED);

    // Lock FSM, saturating lock counter and the one-cycle reject pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= S_ALIGN;
            r_lock_cnt <= '0;
            r_err      <= 1'b0;
        end else if (PWRDWN) begin
            r_state    <= S_DOWN;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_reject;
            case (r_state)
                S_ALIGN: begin
                    r_state    <= S_RUN_WAIT;
                    r_lock_cnt <= '0;
                end
                S_RUN_WAIT: begin
                    if (w_accept) begin
                        r_state <= S_ALIGN;
                    end else if (r_lock_cnt >= LK_W'(LOCK_CYCLES - 1)) begin
                        r_state <= S_LOCKED;
                    end
                    if (r_lock_cnt != LK_W'(LOCK_CYCLES)) begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_accept) begin
                        r_state <= S_ALIGN;
                    end
                end
                S_DOWN: begin
                    r_state <= S_ALIGN;
                end
                default: begin
                    r_state <= S_ALIGN;
                end
            endcase
        end
    end

    // Per-channel configuration registers; persist through power-down.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (RST) begin
                r_div[ch]   <= DEF_DIV;
                r_high[ch]  <= DEF_HIGH;
                r_phase[ch] <= '0;
            end else if (w_accept && (w_sel_ext == ch)) begin
                r_div[ch]   <= cfg_divide;
                r_high[ch]  <= cfg_high;
                r_phase[ch] <= cfg_phase;
            end
        end
    end

    // Channel counters and registered outputs. On an accept the outputs are
    // parked low and the counters wait for ALIGN so every channel restarts
    // on the same cycle.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (RST) begin
                r_delay[ch]  <= '0;
                r_period[ch] <= '0;
                r_clk[ch]    <= 1'b0;
            end else if (PWRDWN || (r_state == S_DOWN)) begin
                r_clk[ch]    <= 1'b0;
            end else if (r_state == S_ALIGN) begin
                r_delay[ch]  <= r_phase[ch];
                r_period[ch] <= '0;
                r_clk[ch]    <= 1'b0;
            end else if (w_accept) begin
                r_clk[ch]    <= 1'b0;
            end else begin
                r_clk[ch] <= (r_delay[ch] == '0) && (r_period[ch] < r_high[ch]);
                if (r_delay[ch] != '0) begin
                    r_delay[ch]  <= r_delay[ch] - 1'b1;
                    r_period[ch] <= '0;
                end else if (r_period[ch] == r_div[ch] - 1'b1) begin
                    r_period[ch] <= '0;
                end else begin
                    r_period[ch] <= r_period[ch] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_gen.sv
// Directed testbench for pll_reconfig_gen (4 channels, 8-bit counters).
// Inputs are driven just after the falling edge and outputs sampled 1ns
// later, so each observation belongs to one well-defined VCO cycle.
module tb_pll_reconfig_gen;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int SW = 2;

    logic          clk        = 1'b0;
    logic          RST        = 1'b1;
    logic          PWRDWN     = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic [SW-1:0] cfg_sel    = '0;
    logic [CW-1:0] cfg_divide = '0;
    logic [CW-1:0] cfg_high   = '0;
    logic [CW-1:0] cfg_phase  = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic [CH-1:0] clk_out;
    logic          LOCKED;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int t0    = 0;
    int m_div  [CH];
    int m_high [CH];
    int m_ph   [CH];

    pll_reconfig_gen #(
        .CHANNELS(CH),
        .CNT_W(CW),
        .DEFAULT_DIVIDE(4),
        .LOCK_CYCLES(16)
    ) dut (
        .clk(clk),
        .RST(RST),
        .PWRDWN(PWRDWN),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel),
        .cfg_divide(cfg_divide),
        .cfg_high(cfg_high),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .clk_out(clk_out),
        .LOCKED(LOCKED)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input int sel, input int d, input int h, input int p);
        cfg_valid  = 1'b1;
        cfg_sel    = SW'(sel);
        cfg_divide = CW'(d);
        cfg_high   = CW'(h);
        cfg_phase  = CW'(p);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_div[c]  = 4;
            m_high[c] = 2;
            m_ph[c]   = 0;
        end
    endtask

    // Expected output k cycles after the first RUN_WAIT cycle.
    function automatic logic exp_bit(input int k, input int d, input int h, input int p);
        if (k <= p) return 1'b0;
        return ((k - p - 1) % d) < h;
    endfunction

    function automatic logic [CH-1:0] exp_vec();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = exp_bit(cyc_n - t0, m_div[c], m_high[c], m_ph[c]);
        return v;
    endfunction

    task automatic test_reset();
        model_reset();
        cyc(); cyc(); cyc();
        total++; if (clk_out !== '0) begin bad++; $display("FAIL reset_clk got=%b want=0000", clk_out); end
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", LOCKED); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cfg_ready); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
        RST = 1'b0;
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL align_ready got=%b want=0", cfg_ready); end
        t0 = cyc_n + 1;
    endtask

    task automatic test_run();
        for (int i = 0; i < 24; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL run_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (LOCKED !== ((cyc_n - t0) >= 16)) begin bad++; $display("FAIL run_locked k=%0d got=%b", cyc_n - t0, LOCKED); end
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL run_ready k=%0d got=%b want=1", cyc_n - t0, cfg_ready); end
        end
    endtask

    task automatic test_reconfig();
        send(2, 10, 3, 5);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL recfg_ready got=%b want=1", cfg_ready); end
        cyc();
        cfg_valid = 1'b0;
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL recfg_align_locked got=%b want=0", LOCKED); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL recfg_align_ready got=%b want=0", cfg_ready); end
        total++; if (clk_out !== '0) begin bad++; $display("FAIL recfg_align_clk got=%b want=0000", clk_out); end
        m_div[2] = 10; m_high[2] = 3; m_ph[2] = 5;
        t0 = cyc_n + 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL recfg_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (LOCKED !== ((cyc_n - t0) >= 16)) begin bad++; $display("FAIL recfg_locked k=%0d got=%b", cyc_n - t0, LOCKED); end
        end
    endtask

    task automatic test_invalid();
        // high == divide, then divide == 1: both rejected
        for (int r = 0; r < 2; r++) begin
            if (r == 0) send(1, 6, 6, 0);
            else        send(1, 1, 0, 0);
            cyc();
            cfg_valid = 1'b0;
            total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL inv_err r=%0d got=%b want=1", r, cfg_err); end
            total++; if (LOCKED !== 1'b1) begin bad++; $display("FAIL inv_locked r=%0d got=%b want=1", r, LOCKED); end
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL inv_ready r=%0d got=%b want=1", r, cfg_ready); end
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL inv_clk r=%0d got=%b want=%b", r, clk_out, exp_vec()); end
            cyc();
            total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL inv_err_len r=%0d got=%b want=0", r, cfg_err); end
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL inv_clk2 r=%0d got=%b want=%b", r, clk_out, exp_vec()); end
        end
        send(3, 6, 3, 0);
        cyc();
        cfg_valid = 1'b0;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL valid3_err got=%b want=0", cfg_err); end
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL valid3_locked got=%b want=0", LOCKED); end
        m_div[3] = 6; m_high[3] = 3; m_ph[3] = 0;
        t0 = cyc_n + 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL valid3_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (LOCKED !== ((cyc_n - t0) >= 16)) begin bad++; $display("FAIL valid3_locked k=%0d got=%b", cyc_n - t0, LOCKED); end
        end
    endtask

    task automatic test_pwrdwn();
        // A request offered on the PWRDWN rising cycle must not be taken.
        PWRDWN = 1'b1;
        send(0, 8, 4, 0);
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pd_ready_now got=%b want=0", cfg_ready); end
        cyc();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pd_ready got=%b want=0", cfg_ready); end
        for (int i = 0; i < 19; i++) begin
            total++; if (clk_out !== '0) begin bad++; $display("FAIL pd_clk i=%0d got=%b want=0000", i, clk_out); end
            total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL pd_locked i=%0d got=%b want=0", i, LOCKED); end
            cyc();
        end
        PWRDWN = 1'b0;
        cyc();
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL pd_align_locked got=%b want=0", LOCKED); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pd_align_ready got=%b want=0", cfg_ready); end
        total++; if (clk_out !== '0) begin bad++; $display("FAIL pd_align_clk got=%b want=0000", clk_out); end
        t0 = cyc_n + 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL pd_relock_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (LOCKED !== ((cyc_n - t0) >= 16)) begin bad++; $display("FAIL pd_relock_locked k=%0d got=%b", cyc_n - t0, LOCKED); end
        end
    endtask

    task automatic test_reset_mid();
        send(2, 7, 2, 3);
        RST = 1'b1;
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", cfg_ready); end
        cyc();
        RST = 1'b0;
        cfg_valid = 1'b0;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b want=0", cfg_err); end
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL rstmid_locked got=%b want=0", LOCKED); end
        total++; if (clk_out !== '0) begin bad++; $display("FAIL rstmid_clk0 got=%b want=0000", clk_out); end
        model_reset();
        t0 = cyc_n + 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL rstmid_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rstmid_err k=%0d got=%b want=0", cyc_n - t0, cfg_err); end
        end
    endtask

    task automatic test_boundary();
        send(3, 2, 1, 0);
        cyc();
        cfg_valid = 1'b0;
        cyc();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL bnd_ready got=%b want=1", cfg_ready); end
        send(0, 255, 254, 254);
        cyc();
        cfg_valid = 1'b0;
        total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL bnd_align_locked got=%b want=0", LOCKED); end
        m_div[3] = 2;   m_high[3] = 1;   m_ph[3] = 0;
        m_div[0] = 255; m_high[0] = 254; m_ph[0] = 254;
        t0 = cyc_n + 1;
        for (int i = 0; i < 520; i++) begin
            cyc();
            total++; if (clk_out !== exp_vec()) begin bad++; $display("FAIL bnd_clk k=%0d got=%b want=%b", cyc_n - t0, clk_out, exp_vec()); end
            total++; if (LOCKED !== ((cyc_n - t0) >= 16)) begin bad++; $display("FAIL bnd_locked k=%0d got=%b", cyc_n - t0, LOCKED); end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_reconfig();
        test_invalid();
        test_pwrdwn();
        test_reset_mid();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_gen.md
Name: pll_reconfig_gen

Overview:
- Cycle-based, synthesisable successor to the 7-series PLL simulation models.
- Derives CHANNELS output clocks from one fast VCO clock by counter division. Each channel has its own programmable divide, high time and phase offset, all in VCO cycles.
- Adds what the base PLL model lacks: runtime reconfiguration via a valid/ready handshake, config validation, and a lock FSM that re-aligns all channels after every change.
- Sits below the PLLE2/MMCM wrappers as the shared output stage.

Parameters:
- CHANNELS, 6: number of output clocks (1-16).
- CNT_W, 8: width of the divide, high and phase counters.
- DEFAULT_DIVIDE, 4: per-channel divide after reset (2 to 2^CNT_W-1).
- LOCK_CYCLES, 16: VCO cycles in RUN_WAIT before LOCKED asserts (at least 1).
- SEL_W (derived): max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  VCO clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PWRDWN  in  1  synchronous power-down.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_sel  in  SEL_W  target channel.
- cfg_divide  in  CNT_W  new period in VCO cycles.
- cfg_high  in  CNT_W  new high time in VCO cycles.
- cfg_phase  in  CNT_W  new start delay in VCO cycles.
- cfg_err  out  1  one-cycle pulse: request rejected.
- clk_out  out  CHANNELS  generated clocks.
- LOCKED  out  1  all channels running with the current config.

Behaviour:
- Priority: RST > PWRDWN > config accept > normal counting.
- Reset values:
  - clk_out=0, LOCKED=0, cfg_ready=0, cfg_err=0.
  - Every channel: divide=DEFAULT_DIVIDE, high=DEFAULT_DIVIDE/2 (truncated), phase=0.
  - FSM goes to ALIGN.
- FSM states ALIGN, RUN_WAIT, LOCKED, DOWN:
  - ALIGN lasts exactly 1 cycle. Each channel loads its delay counter with phase, clears its period counter and forces clk_out=0. Next state is RUN_WAIT.
  - RUN_WAIT: channels run and the lock counter counts. After LOCK_CYCLES cycles go to LOCKED; LOCKED=1 from the first cycle in LOCKED.
  - LOCKED: channels run; LOCKED=1.
  - DOWN: entered from any state when PWRDWN=1. clk_out=0, LOCKED=0, counters frozen. When PWRDWN=0, go to ALIGN.
- Channel timing, with t0 = first RUN_WAIT cycle:
  - While the delay counter is nonzero it decrements and the period counter holds at 0.
  - Once the delay counter reaches 0, the period counter counts 0..divide-1 and wraps to 0.
  - clk_out is registered as (delay counter==0 && period counter<high).
  - Result: first rising edge at t0+phase+1, period = divide cycles, high for exactly `high` cycles.
- Handshake:
  - cfg_ready=1 only in RUN_WAIT or LOCKED with PWRDWN=0 and RST=0.
  - A transfer occurs on a cycle where cfg_valid && cfg_ready.
  - Valid request: all of 2<=divide, 1<=high<divide, phase<divide, cfg_sel<CHANNELS.
  - Accepting a valid request writes the selected channel's config registers.
  - Next cycle: FSM is in ALIGN, LOCKED=0, cfg_ready=0, and all channels restart together so relative phases are preserved.
  - Accepting an invalid request: cfg_err=1 for exactly the next cycle. Config, FSM and LOCKED are unchanged and cfg_ready stays 1.
- Simultaneous events:
  - RST during a transfer: the config is discarded and reset values apply.
  - PWRDWN rising on the accept cycle: the transfer is not taken (cfg_ready is 0) and the FSM goes to DOWN.
  - Config registers persist through DOWN.
- Counter wrap: the period counter wraps at divide-1, never at 2^CNT_W. The lock counter saturates.
- No combinational path from cfg_* to cfg_ready or clk_out.

Test Plan (CHANNELS=4, CNT_W=8, DEFAULT_DIVIDE=4, LOCK_CYCLES=16):
1. Reset, then run:
   - RST high 3 cycles, then low.
   - All clk_out rise together at t0+1, period 4, high 2.
   - LOCKED=1 at t0+16; cfg_ready=1 from t0.
2. Valid reconfig of channel 2:
   - After lock, send sel=2, divide=10, high=3, phase=5.
   - Next cycle LOCKED=0 and ALIGN.
   - ch2 first rises at t0+6, then period 10, high 3; ch0/1/3 unchanged at period 4.
   - LOCKED=1 at t0+16.
3. Invalid request:
   - Send sel=1, divide=6, high=6.
   - cfg_err pulses 1 cycle; LOCKED stays 1; ch1 output unchanged. Repeat with divide=1 and with sel=3 valid: only the sel=3 request reconfigures.
4. Power-down:
   - PWRDWN high for 20 cycles while locked.
   - clk_out=0, LOCKED=0, cfg_ready=0 the cycle after PWRDWN rises.
   - On release: ALIGN, then relock after 16 cycles with the previously programmed config.
5. Reset mid-reconfig:
   - Assert RST on the accept cycle.
   - All channels return to divide 4 and phase 0; no cfg_err.
6. Boundary values:
   - divide=255, high=254, phase=254 on ch0: first rise at t0+255, period 255, high 254, no counter overflow.
   - divide=2, high=1 on ch3: toggles every cycle.
